// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: ALU operation codes, forwarding selects and
// the EX/MEM pipeline register layout.
package pipeline_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        zero;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU; unused operation codes produce 0.
module alu
  import pipeline_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] y,
  output logic        zero
);

  // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    y = '0;
    case (alu_control)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU, destination select and the EX/MEM
// pipeline register with stall (hold) and flush (bubble) control.
module execute_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd1_E,
  input  logic [31:0] rd2_E,
  input  logic [31:0] sign_imm_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  rd_E,
  input  logic        reg_dst_E,
  input  logic        alu_src_E,
  input  logic        reg_write_E,
  input  logic        mem_to_reg_E,
  input  logic        mem_write_E,
  input  logic [2:0]  alu_control_E,
  input  logic [1:0]  forward_a_E,
  input  logic [1:0]  forward_b_E,
  input  logic [31:0] result_W,
  input  logic        stall_M,
  input  logic        flush_M,
  output logic [4:0]  write_reg_E,
  output logic [31:0] alu_out_M,
  output logic [31:0] write_data_M,
  output logic [4:0]  write_reg_M,
  output logic        reg_write_M,
  output logic        mem_to_reg_M,
  output logic        mem_write_M,
  output logic        zero_M
);

  ex_mem_t     ex_mem_q;
  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_y;
  logic        alu_zero;

  // Select 11 is unused by the forwarding unit and falls back to the register file.
  always_comb begin
    src_a = rd1_E;
    case (forward_a_E)
      FWD_WB:  src_a = result_W;
      FWD_MEM: src_a = ex_mem_q.alu_out;
      default: src_a = rd1_E;
    endcase
  end

  always_comb begin
    fwd_b = rd2_E;
    case (forward_b_E)
      FWD_WB:  fwd_b = result_W;
      FWD_MEM: fwd_b = ex_mem_q.alu_out;
      default: fwd_b = rd2_E;
    endcase
  end

  assign src_b       = alu_src_E ? sign_imm_E : fwd_b;
  assign write_reg_E = reg_dst_E ? rd_E : rt_E;

  alu u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (alu_control_E),
    .y           (alu_y),
    .zero        (alu_zero)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_q <= '0;
    end else if (flush_M) begin
      ex_mem_q <= '0;
    end else if (!stall_M) begin
      ex_mem_q <= '{alu_out:    alu_y,
                    write_data: fwd_b,
                    write_reg:  write_reg_E,
                    reg_write:  reg_write_E,
                    mem_to_reg: mem_to_reg_E,
                    mem_write:  mem_write_E,
                    zero:       alu_zero};
    end
  end

  assign alu_out_M    = ex_mem_q.alu_out;
  assign write_data_M = ex_mem_q.write_data;
  assign write_reg_M  = ex_mem_q.write_reg;
  assign reg_write_M  = ex_mem_q.reg_write;
  assign mem_to_reg_M = ex_mem_q.mem_to_reg;
  assign mem_write_M  = ex_mem_q.mem_write;
  assign zero_M       = ex_mem_q.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: behavioural model compared every
// falling edge, directed literal cases, then randomized traffic.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] rd1_E = '0, rd2_E = '0, sign_imm_E = '0, result_W = '0;
  logic [4:0]  rt_E = '0, rd_E = '0;
  logic        reg_dst_E = 0, alu_src_E = 0, reg_write_E = 0, mem_to_reg_E = 0, mem_write_E = 0;
  logic [2:0]  alu_control_E = '0;
  logic [1:0]  forward_a_E = '0, forward_b_E = '0;
  logic        stall_M = 0, flush_M = 0;
  logic [4:0]  write_reg_E;
  logic [31:0] alu_out_M, write_data_M;
  logic [4:0]  write_reg_M;
  logic        reg_write_M, mem_to_reg_M, mem_write_M, zero_M;

  int compared = 0;
  int mismatched = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .rd1_E(rd1_E), .rd2_E(rd2_E), .sign_imm_E(sign_imm_E),
    .rt_E(rt_E), .rd_E(rd_E), .reg_dst_E(reg_dst_E), .alu_src_E(alu_src_E),
    .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E), .mem_write_E(mem_write_E),
    .alu_control_E(alu_control_E), .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
    .result_W(result_W), .stall_M(stall_M), .flush_M(flush_M), .write_reg_E(write_reg_E),
    .alu_out_M(alu_out_M), .write_data_M(write_data_M), .write_reg_M(write_reg_M),
    .reg_write_M(reg_write_M), .mem_to_reg_M(mem_to_reg_M), .mem_write_M(mem_write_M),
    .zero_M(zero_M)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the M-side state.
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_wr;
  logic        m_rw, m_mtr, m_mw, m_zero;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    if (op == 3'd0) return a & b;
    if (op == 3'd1) return a | b;
    if (op == 3'd2) return a + b;
    if (op == 3'd6) return a - b;
    if (op == 3'd7) return (sa < sb) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || (rst_n && flush_M)) begin
      m_alu <= '0; m_wd <= '0; m_wr <= '0; m_rw <= 0; m_mtr <= 0; m_mw <= 0; m_zero <= 0;
    end else if (!stall_M) begin
      logic [31:0] a, b, y;
      a = pick(forward_a_E, rd1_E, result_W, m_alu);
      b = pick(forward_b_E, rd2_E, result_W, m_alu);
      y = alu_ref(alu_control_E, a, alu_src_E ? sign_imm_E : b);
      m_alu  <= y;
      m_zero <= (y == 0);
      m_wd   <= b;
      m_wr   <= reg_dst_E ? rd_E : rt_E;
      m_rw   <= reg_write_E;
      m_mtr  <= mem_to_reg_E;
      m_mw   <= mem_write_E;
    end
  end

  always @(negedge clk) begin
    check("alu_out_M", alu_out_M, m_alu);
    check("write_data_M", write_data_M, m_wd);
    check("write_reg_M", 32'(write_reg_M), 32'(m_wr));
    check("ctrl_M", {28'd0, reg_write_M, mem_to_reg_M, mem_write_M, zero_M},
          {28'd0, m_rw, m_mtr, m_mw, m_zero});
    check("write_reg_E", 32'(write_reg_E), 32'(reg_dst_E ? rd_E : rt_E));
  end

  task automatic check_all_zero(input string name);
    check(name, {alu_out_M | write_data_M, 20'd0, write_reg_M, reg_write_M, mem_to_reg_M,
                 mem_write_M, zero_M}, '0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [1:0] fa, input logic [1:0] fb);
    rd1_E = a; rd2_E = b; alu_control_E = op; forward_a_E = fa; forward_b_E = fb;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_state");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 5 + 3, rd destination
    set_op(32'd5, 32'd3, 3'b010, 2'b00, 2'b00);
    reg_dst_E = 1; rd_E = 5'd7; rt_E = 5'd2; reg_write_E = 1;
    step();
    check("add_alu", alu_out_M, 32'd8);
    check("add_wreg", 32'(write_reg_M), 32'd7);
    check("add_zero", 32'(zero_M), 32'd0);

    // forward previous alu_out (8) into A, 8 - 8
    set_op(32'd1, 32'd8, 3'b110, 2'b10, 2'b00);
    step();
    check("sub_fwd_alu", alu_out_M, 32'd0);
    check("sub_fwd_zero", 32'(zero_M), 32'd1);

    // B from writeback = -1; signed 0 < -1 is false
    set_op(32'd0, 32'd55, 3'b111, 2'b00, 2'b01);
    result_W = 32'hFFFF_FFFF;
    step();
    check("slt_alu", alu_out_M, 32'd0);
    check("slt_wdata", write_data_M, 32'hFFFF_FFFF);

    // immediate -4 added to 0x10, store
    set_op(32'h10, 32'h1234, 3'b010, 2'b00, 2'b00);
    alu_src_E = 1; sign_imm_E = 32'hFFFF_FFFC; mem_write_E = 1;
    step();
    check("imm_alu", alu_out_M, 32'h0C);
    check("imm_memw", 32'(mem_write_M), 32'd1);
    check("imm_wdata", write_data_M, 32'h1234);

    // stall holds for two cycles despite changing inputs
    stall_M = 1;
    for (int i = 0; i < 2; i++) begin
      set_op($urandom, $urandom, 3'b001, 2'b10, 2'b01);
      result_W = $urandom; mem_write_E = 0; alu_src_E = 0; rd_E = 5'd30;
      step();
      check("stall_alu", alu_out_M, 32'h0C);
      check("stall_wdata", write_data_M, 32'h1234);
      check("stall_memw", 32'(mem_write_M), 32'd1);
      check("stall_wreg", 32'(write_reg_M), 32'd7);
    end
    flush_M = 1;
    step();
    check_all_zero("flush_over_stall");
    stall_M = 0; flush_M = 0;

    // asynchronous reset between edges
    set_op(32'd5, 32'd3, 3'b010, 2'b00, 2'b00);
    alu_src_E = 0;
    step();
    check("pre_reset_alu", alu_out_M, 32'd8);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    #1 rst_n = 1'b1;
    step();
    check("resume_after_reset", alu_out_M, 32'd8);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] mode = 2'($urandom_range(0, 3));
      rd1_E = (mode == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      rd2_E = (mode == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      sign_imm_E = (mode == 1) ? 32'(signed'(16'($urandom))) : $urandom;
      result_W = $urandom;
      rt_E = 5'($urandom); rd_E = 5'($urandom);
      {reg_dst_E, alu_src_E, reg_write_E, mem_to_reg_E, mem_write_E} = 5'($urandom);
      alu_control_E = 3'($urandom_range(0, 7));
      forward_a_E = 2'($urandom_range(0, 3));
      forward_b_E = 2'($urandom_range(0, 3));
      stall_M = ($urandom_range(0, 5) == 0);
      flush_M = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL expose clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL expose rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL expose rd1_E, rd2_E  input  32 each  register-file operands from ID/EX.
REQ-004 SHALL expose sign_imm_E  input  32  sign-extended immediate.
REQ-005 SHALL expose rt_E, rd_E  input  5 each  candidate destination registers.
REQ-006 SHALL expose reg_dst_E, alu_src_E, reg_write_E, mem_to_reg_E, mem_write_E  input  1 each  EX-stage control.
REQ-007 SHALL expose alu_control_E  input  3  ALU operation code.
REQ-008 SHALL expose forward_a_E, forward_b_E  input  2 each  operand select from the forwarding unit.
REQ-009 SHALL expose result_W  input  32  writeback-stage result for forwarding.
REQ-010 SHALL expose stall_M  input  1  hold the EX/MEM register.
REQ-011 SHALL expose flush_M  input  1  load a bubble into the EX/MEM register.
REQ-012 SHALL expose write_reg_E  output  5  combinational destination register, for the hazard unit.
REQ-013 SHALL expose alu_out_M, write_data_M  output  32 each  registered ALU result and store data.
REQ-014 SHALL expose write_reg_M  output  5  registered destination register.
REQ-015 SHALL expose reg_write_M, mem_to_reg_M, mem_write_M, zero_M  output  1 each  registered control and ALU zero flag.

Function
REQ-016 SHALL drive srcA as: rd1_E for select 00; result_W for 01; alu_out_M for 10; rd1_E for 11.
REQ-017 SHALL drive the forwarded B value with the same rule applied to rd2_E.
REQ-018 SHALL drive srcB as: sign_imm_E when alu_src_E=1, otherwise the forwarded B value.
REQ-019 SHALL drive write_reg_E as rd_E when reg_dst_E=1, otherwise rt_E.
REQ-020 SHALL compute the ALU result from alu_control_E, with all arithmetic mod 2^32 and overflow ignored:
- 000 AND; 001 OR; 010 ADD.
- 110 SUB; 111 signed SLT (result 1 or 0, zero-extended).
- 011, 100, 101 yield 0.
REQ-021 SHALL assert zero when the 32-bit ALU result equals 0.
REQ-022 SHALL register these fields into the M outputs on each rising edge when stall_M=0 and flush_M=0, giving exactly one cycle of latency:
- the ALU result and zero;
- the forwarded B value (not srcB) as write_data_M;
- write_reg_E, reg_write_E, mem_to_reg_E, mem_write_E.
REQ-023 SHALL hold every M output unchanged while stall_M=1 and flush_M=0.
REQ-024 SHALL clear every M output to 0 on the edge when flush_M=1, regardless of stall_M (flush wins).
REQ-025 SHALL use the current registered alu_out_M for forwarding select 10, including while stalled.
REQ-026 SHALL have no combinational path from any input to any M output.

Reset
REQ-027 SHALL clear alu_out_M, write_data_M, write_reg_M, reg_write_M, mem_to_reg_M, mem_write_M and zero_M to 0 immediately on rst_n low.
REQ-028 SHALL hold those zero values while rst_n=0, regardless of clk.
REQ-029 SHALL resume normal capture on the first rising edge after rst_n deasserts.
REQ-030 SHALL discard any operation in flight when reset is asserted mid-operation.

Structure
REQ-031 SHALL take these constants from a shared package pipeline_pkg:
- ALU codes ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT;
- forward selects FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-032 SHALL instantiate one combinational sub-module, alu (inputs a, b, alu_control; outputs y, zero).
REQ-033 SHALL keep the operand muxes and the EX/MEM register in execute_stage itself.

Verification
REQ-034 SHALL cover: rd1_E=5, rd2_E=3, ADD, forwards 00, reg_dst_E=1, rd_E=7 -> next cycle alu_out_M=8, write_reg_M=7, zero_M=0.
REQ-035 SHALL cover: previous result alu_out_M=8 with forward_a_E=10, rd1_E=1, rd2_E=8, SUB -> alu_out_M=0, zero_M=1.
REQ-036 SHALL cover: forward_b_E=01, result_W=0xFFFF_FFFF, rd1_E=0, SLT, alu_src_E=0 -> alu_out_M=0 (signed 0 < -1 is false); write_data_M=0xFFFF_FFFF.
REQ-037 SHALL cover: alu_src_E=1, sign_imm_E=0xFFFF_FFFC, rd1_E=0x10, ADD, mem_write_E=1 -> alu_out_M=0x0C, mem_write_M=1, write_data_M=rd2_E.
REQ-038 SHALL cover: stall_M=1 for 2 cycles with changing inputs -> M outputs constant; then flush_M=1 with stall_M=1 -> all M outputs 0.
REQ-039 SHALL cover: rst_n pulsed low between clock edges with nonzero M outputs -> all M outputs 0 before the next edge.
